// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// Build option: define MISALIGN_TRAP_EN to reject misaligned half/word accesses.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        SZ_NONE = 2'b00,
        SZ_BYTE = 2'b01,
        SZ_HALF = 2'b10,
        SZ_WORD = 2'b11
    } mem_size_t;

    localparam int MEM_WORD_BYTES = 4;

    // True when a base-relative byte offset lands inside a window of 'words' words.
    function automatic logic in_window(input logic [31:0] offset, input int unsigned words);
        return {1'b0, offset} < (33'(words) * 33'(MEM_WORD_BYTES));
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Load/store request bus between the execute stage (master) and the data RAM (slave).
interface data_mem_responder_if
    import data_mem_responder_pkg::*;
();

    logic        read;
    logic [31:0] read_address;
    logic        write;
    logic [31:0] write_address;
    logic [31:0] write_data;
    mem_size_t   size;
    logic [31:0] data_out;
    logic        data_valid;
    logic        error;
    logic [15:0] err_count;

    modport master (
        output read, read_address, write, write_address, write_data, size,
        input  data_out, data_valid, error, err_count
    );

    modport slave (
        input  read, read_address, write, write_address, write_data, size,
        output data_out, data_valid, error, err_count
    );

endinterface

// File: rtl/data_mem_responder_lane_decode.sv
// Maps access size and byte offset to lane enables, replicated store data and a
// misalignment flag; purely combinational.
module data_mem_responder_lane_decode
    import data_mem_responder_pkg::*;
(
    input  mem_size_t   i_size,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_word,
    output logic        o_misaligned
);

    always_comb begin
        o_be         = 4'b0000;
        o_word       = i_data;
        o_misaligned = 1'b0;
        case (i_size)
            SZ_BYTE: begin
                o_be   = 4'b0001 << i_offset;
                o_word = {4{i_data[7:0]}};
            end
            SZ_HALF: begin
                // offset[0] is ignored for lane selection, so a misaligned half
                // naturally lands on its aligned lane pair.
                o_be         = i_offset[1] ? 4'b1100 : 4'b0011;
                o_word       = {2{i_data[15:0]}};
                o_misaligned = i_offset[0];
            end
            SZ_WORD: begin
                o_be         = 4'b1111;
                o_misaligned = |i_offset;
            end
            default: begin
                o_be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Local data RAM / bus endpoint: byte-lane writes, fixed-latency aligned word reads,
// window and alignment error reporting. Build option: MISALIGN_TRAP_EN.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          READ_LAT  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  mem
);

    localparam int AW  = $clog2(MEM_WORDS);
    localparam int DLY = (READ_LAT > 1) ? READ_LAT - 1 : 1;

    logic [31:0] r_mem [MEM_WORDS];
    logic [15:0] r_err_count;

    logic [31:0]   w_wr_off;
    logic [31:0]   w_rd_off;
    logic          w_wr_in_win;
    logic          w_rd_in_win;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    logic [3:0]    w_wr_be;
    logic [31:0]   w_wr_word;
    logic          w_wr_mis;
    logic [3:0]    w_rd_be;
    logic [31:0]   w_rd_word;
    logic          w_rd_mis;
    logic          w_wr_trap;
    logic          w_rd_trap;
    logic          w_wr_err;
    logic          w_rd_err;
    logic          w_wr_en;
    logic          w_rd_ok;
    logic          w_err_any;
    logic          w_rd_unused;

    logic              w_pipe_in_vld;
    logic [31:0]       w_pipe_in_word;
    logic [DLY:0]      w_chain_vld;
    logic [DLY:0][31:0] w_chain_word;

    assign w_wr_off    = mem.write_address - BASE_ADDR;
    assign w_rd_off    = mem.read_address - BASE_ADDR;
    assign w_wr_in_win = in_window(w_wr_off, MEM_WORDS);
    assign w_rd_in_win = in_window(w_rd_off, MEM_WORDS);
    assign w_wr_idx    = w_wr_off[AW+1:2];
    assign w_rd_idx    = w_rd_off[AW+1:2];

    data_mem_responder_lane_decode u_wr_lanes (
        .i_size       (mem.size),
        .i_offset     (w_wr_off[1:0]),
        .i_data       (mem.write_data),
        .o_be         (w_wr_be),
        .o_word       (w_wr_word),
        .o_misaligned (w_wr_mis)
    );

    data_mem_responder_lane_decode u_rd_lanes (
        .i_size       (mem.size),
        .i_offset     (w_rd_off[1:0]),
        .i_data       (32'h0),
        .o_be         (w_rd_be),
        .o_word       (w_rd_word),
        .o_misaligned (w_rd_mis)
    );

    // Reads always return the whole aligned word; only the alignment flag matters here.
    assign w_rd_unused = ^{w_rd_be, w_rd_word};

`ifdef MISALIGN_TRAP_EN
    assign w_wr_trap = w_wr_mis;
    assign w_rd_trap = w_rd_mis;
`else
    logic w_mis_unused;
    assign w_mis_unused = w_wr_mis ^ w_rd_mis;
    assign w_wr_trap    = 1'b0;
    assign w_rd_trap    = 1'b0;
`endif

    assign w_wr_err  = mem.write & ((mem.size == SZ_NONE) | ~w_wr_in_win | w_wr_trap);
    assign w_wr_en   = mem.write & ~w_wr_err;
    assign w_rd_ok   = w_rd_in_win & ~w_rd_trap;
    assign w_rd_err  = mem.read & ~w_rd_ok;
    assign w_err_any = reset & (w_wr_err | w_rd_err);
    assign mem.error = w_err_any;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_count <= 16'h0000;
        end else if (w_err_any && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'h0001;
        end
    end

    assign mem.err_count = r_err_count;

    // Storage is deliberately outside the reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < MEM_WORD_BYTES; b++) begin
                if (w_wr_be[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= w_wr_word[8*b +: 8];
                end
            end
        end
    end

    generate
        if (READ_LAT == 1) begin : g_lat1
            // Single-cycle latency: forward the same-edge store into the read word.
            logic [31:0] w_fwd_word;
            always_comb begin
                w_fwd_word = r_mem[w_rd_idx];
                if (w_wr_en && (w_wr_idx == w_rd_idx)) begin
                    for (int b = 0; b < MEM_WORD_BYTES; b++) begin
                        if (w_wr_be[b]) begin
                            w_fwd_word[8*b +: 8] = w_wr_word[8*b +: 8];
                        end
                    end
                end
                if (!w_rd_ok) begin
                    w_fwd_word = 32'h0;
                end
            end
            assign w_pipe_in_vld  = mem.read;
            assign w_pipe_in_word = w_fwd_word;
        end else begin : g_latn
            logic          r_rd_vld;
            logic          r_rd_ok;
            logic [AW-1:0] r_rd_idx;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_rd_vld <= 1'b0;
                    r_rd_ok  <= 1'b0;
                    r_rd_idx <= '0;
                end else begin
                    r_rd_vld <= mem.read;
                    if (mem.read) begin
                        r_rd_ok  <= w_rd_ok;
                        r_rd_idx <= w_rd_idx;
                    end
                end
            end
            // The index is registered after the strobe edge, so a store on that
            // same edge is already in the array: write-first for free.
            assign w_pipe_in_vld  = r_rd_vld;
            assign w_pipe_in_word = r_rd_ok ? r_mem[r_rd_idx] : 32'h0;
        end
    endgenerate

    assign w_chain_vld[0]  = w_pipe_in_vld;
    assign w_chain_word[0] = w_pipe_in_word;

    generate
        for (genvar gi = 0; gi < DLY; gi++) begin : g_dly
            logic        r_vld;
            logic [31:0] r_word;
            // Words only advance with a valid beat, so the last stage holds its value.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_vld  <= 1'b0;
                    r_word <= 32'h0;
                end else begin
                    r_vld <= w_chain_vld[gi];
                    if (w_chain_vld[gi]) begin
                        r_word <= w_chain_word[gi];
                    end
                end
            end
            assign w_chain_vld[gi+1]  = r_vld;
            assign w_chain_word[gi+1] = r_word;
        end
    endgenerate

    assign mem.data_valid = w_chain_vld[DLY];
    assign mem.data_out   = w_chain_word[DLY];

endmodule
